// File: rtl/ecc_job_scheduler.sv
// Two-port round-robin job sequencer that programs the ECC core over APB
// and returns the core's result to the requester that issued the job.
module ecc_job_scheduler #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT         = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [3:0]                 req_mode,
    input  logic [3:0]                 req_width,
    input  logic [2*AMBA_WORD-1:0]     req_data,
    input  logic [2*AMBA_WORD-1:0]     req_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       core_done,
    input  logic [DATA_WIDTH-1:0]      core_data,
    input  logic [1:0]                 core_nerr,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_nerr,
    output logic                       rsp_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t state, n_state;

    logic [1:0]           idx, n_idx;
    logic [7:0]           tcnt, n_tcnt;
    logic                 last, n_last;
    logic [1:0]           mode, n_mode;
    logic [1:0]           width, n_width;
    logic [AMBA_WORD-1:0] data, n_data;
    logic [AMBA_WORD-1:0] noise, n_noise;

    logic [1:0]                 grant;
    logic                       sel;
    logic                       n_psel;
    logic                       n_penable;
    logic [AMBA_ADDR_WIDTH-1:0] n_paddr;
    logic [AMBA_WORD-1:0]       n_pwdata;
    logic                       n_rsp_id;
    logic [DATA_WIDTH-1:0]      n_rsp_data;
    logic [1:0]                 n_rsp_nerr;
    logic                       n_rsp_err;

    // On a tie the requester that did not win last time gets the grant
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign sel       = grant[1];

    always_comb begin
        n_state    = state;
        n_idx      = idx;
        n_tcnt     = tcnt;
        n_last     = last;
        n_mode     = mode;
        n_width    = width;
        n_data     = data;
        n_noise    = noise;
        n_rsp_id   = rsp_id;
        n_rsp_data = rsp_data;
        n_rsp_nerr = rsp_nerr;
        n_rsp_err  = rsp_err;
        case (state)
            IDLE: begin
                if (grant != 2'b00) begin
                    n_mode   = sel ? req_mode[3:2]  : req_mode[1:0];
                    n_width  = sel ? req_width[3:2] : req_width[1:0];
                    n_data   = sel ? req_data[2*AMBA_WORD-1:AMBA_WORD]
                                   : req_data[AMBA_WORD-1:0];
                    n_noise  = sel ? req_noise[2*AMBA_WORD-1:AMBA_WORD]
                                   : req_noise[AMBA_WORD-1:0];
                    n_rsp_id = sel;
                    n_last   = sel;
                    n_idx    = 2'd0;
                    if (n_mode == 2'b11) begin
                        n_rsp_err  = 1'b1;
                        n_rsp_data = '0;
                        n_rsp_nerr = 2'b00;
                        n_state    = RESP;
                    end else begin
                        n_state = WR_SETUP;
                    end
                end
            end
            WR_SETUP: n_state = WR_ACCESS;
            WR_ACCESS: begin
                if (idx != 2'd3) begin
                    n_idx   = idx + 2'd1;
                    n_state = WR_SETUP;
                end else begin
                    n_tcnt  = 8'd0;
                    n_state = WAIT;
                end
            end
            WAIT: begin
                n_tcnt = tcnt + 8'd1;
                if (core_done) begin
                    n_rsp_data = core_data;
                    n_rsp_nerr = core_nerr;
                    n_rsp_err  = 1'b0;
                    n_state    = RESP;
                end else if (tcnt == 8'(TIMEOUT - 1)) begin
                    n_rsp_data = '0;
                    n_rsp_nerr = 2'b00;
                    n_rsp_err  = 1'b1;
                    n_state    = RESP;
                end
            end
            RESP:    n_state = IDLE;
            default: n_state = IDLE;
        endcase
    end

    // APB outputs are registered from the next state; CTRL goes last
    always_comb begin
        n_psel    = (n_state == WR_SETUP) || (n_state == WR_ACCESS);
        n_penable = (n_state == WR_ACCESS);
        n_paddr   = '0;
        n_pwdata  = '0;
        if (n_psel) begin
            case (n_idx)
                2'd0: begin
                    n_paddr[3:2] = 2'b10;
                    n_pwdata     = {{(AMBA_WORD-2){1'b0}}, n_width};
                end
                2'd1: begin
                    n_paddr[3:2] = 2'b11;
                    n_pwdata     = n_noise;
                end
                2'd2: begin
                    n_paddr[3:2] = 2'b01;
                    n_pwdata     = n_data;
                end
                default: begin
                    n_paddr[3:2] = 2'b00;
                    n_pwdata     = {{(AMBA_WORD-2){1'b0}}, n_mode};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            tcnt      <= 8'd0;
            last      <= 1'b1;
            mode      <= 2'b00;
            width     <= 2'b00;
            data      <= '0;
            noise     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_nerr  <= 2'b00;
            rsp_err   <= 1'b0;
        end else begin
            state     <= n_state;
            idx       <= n_idx;
            tcnt      <= n_tcnt;
            last      <= n_last;
            mode      <= n_mode;
            width     <= n_width;
            data      <= n_data;
            noise     <= n_noise;
            PSEL      <= n_psel;
            PENABLE   <= n_penable;
            PWRITE    <= n_psel;
            PADDR     <= n_paddr;
            PWDATA    <= n_pwdata;
            rsp_valid <= (n_state == RESP);
            rsp_id    <= n_rsp_id;
            rsp_data  <= n_rsp_data;
            rsp_nerr  <= n_rsp_nerr;
            rsp_err   <= n_rsp_err;
        end
    end

endmodule

// File: tb/tb_ecc_job_scheduler.sv
// Directed vector bench for ecc_job_scheduler: APB write sequence,
// response timing, arbitration, timeout, illegal mode and mid-job reset.
module tb_ecc_job_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_mode = '0;
    logic [3:0]  req_width = '0;
    logic [63:0] req_data = '0;
    logic [63:0] req_noise = '0;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic        core_done = 1'b0;
    logic [31:0] core_data = '0;
    logic [1:0]  core_nerr = '0;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_nerr;

    int ncmp = 0;
    int nfail = 0;

    ecc_job_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_width(req_width),
        .req_data(req_data), .req_noise(req_noise),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .core_done(core_done), .core_data(core_data),
        .core_nerr(core_nerr),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_nerr(rsp_nerr),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vmask;
        int          id;
        logic [1:0]  mode;
        logic [1:0]  width;
        logic [31:0] data;
        logic [31:0] noise;
        int          k;
        int          spur;
        logic [31:0] cdata;
        logic [1:0]  cnerr;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [1:0]  exp_nerr;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[9];
    vec_t vr;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] vmask, input int id,
        input logic [1:0] mode, input logic [1:0] width,
        input logic [31:0] data, input logic [31:0] noise,
        input int k, input int spur,
        input logic [31:0] cdata, input logic [1:0] cnerr,
        input logic exp_err, input logic [31:0] exp_data,
        input logic [1:0] exp_nerr, input int exp_cyc);
        vec_t v;
        v.vmask = vmask; v.id = id; v.mode = mode; v.width = width;
        v.data = data; v.noise = noise; v.k = k; v.spur = spur;
        v.cdata = cdata; v.cnerr = cnerr; v.exp_err = exp_err;
        v.exp_data = exp_data; v.exp_nerr = exp_nerr;
        v.exp_cyc = exp_cyc;
        return v;
    endfunction

    function automatic logic [19:0] exp_addr(input int p);
        case (p)
            0:       return 20'h8;
            1:       return 20'hC;
            2:       return 20'h4;
            default: return 20'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input int p, input vec_t v);
        case (p)
            0:       return {30'b0, v.width};
            1:       return v.noise;
            2:       return v.data;
            default: return {30'b0, v.mode};
        endcase
    endfunction

    // The losing lane carries inverted fields so a wrong latch shows up
    task automatic drive_req(input vec_t v);
        if (v.id == 1) begin
            req_mode  = {v.mode, ~v.mode};
            req_width = {v.width, ~v.width};
            req_data  = {v.data, ~v.data};
            req_noise = {v.noise, ~v.noise};
        end else begin
            req_mode  = {~v.mode, v.mode};
            req_width = {~v.width, v.width};
            req_data  = {~v.data, v.data};
            req_noise = {~v.noise, v.noise};
        end
        req_valid = v.vmask;
        core_data = v.cdata;
        core_nerr = v.cnerr;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int got;
        int p;
        got = -1;
        @(negedge clk);
        drive_req(v);
        #1 chk({tag, " ready"}, 64'(req_ready), 64'(2'b01 << v.id));
        @(negedge clk);
        req_valid = 2'b00;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (v.mode != 2'b11 && c <= 8) begin
                p = (c - 1) / 2;
                chk({tag, " apb_ctl"}, 64'({PSEL, PENABLE, PWRITE}),
                    64'({1'b1, (c % 2 == 0), 1'b1}));
                chk({tag, " paddr"}, 64'(PADDR), 64'(exp_addr(p)));
                chk({tag, " pwdata"}, 64'(PWDATA), 64'(exp_wdata(p, v)));
            end else begin
                chk({tag, " apb_idle"}, 64'({PSEL, PENABLE}), 64'(0));
            end
            if (got >= 0 && c == got + 1) begin
                chk({tag, " rsp_pulse"}, 64'(rsp_valid), 64'(0));
                break;
            end else if (rsp_valid && got < 0) begin
                got = c;
                chk({tag, " rsp_id"}, 64'(rsp_id), 64'(v.id));
                chk({tag, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
                chk({tag, " rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
                chk({tag, " rsp_nerr"}, 64'(rsp_nerr), 64'(v.exp_nerr));
            end
            core_done = (v.k >= 0 && c == 9 + v.k) || (c == v.spur);
        end
        core_done = 1'b0;
        chk({tag, " rsp_cycle"}, 64'(got), 64'(v.exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Round-robin with both valid: 0,1,0,1 from reset
        vecs[0] = mk(2'b11, 0, 2'b00, 2'b10, 32'h1234_5678, 32'h0,
                     0, -1, 32'hCAFE_0001, 2'b00, 0, 32'hCAFE_0001, 2'b00, 10);
        vecs[1] = mk(2'b11, 1, 2'b01, 2'b01, 32'h0000_ABCD, 32'h0,
                     3, -1, 32'h0000_00AB, 2'b00, 0, 32'h0000_00AB, 2'b00, 13);
        vecs[2] = mk(2'b11, 0, 2'b10, 2'b00, 32'h0000_0033, 32'h4,
                     1, -1, 32'h0000_0033, 2'b01, 0, 32'h0000_0033, 2'b01, 11);
        vecs[3] = mk(2'b11, 1, 2'b00, 2'b00, 32'h7, 32'h0,
                     5, -1, 32'h0000_0707, 2'b00, 0, 32'h0000_0707, 2'b00, 15);
        // Single encode of 0x5
        vecs[4] = mk(2'b01, 0, 2'b00, 2'b00, 32'h5, 32'h0,
                     2, -1, 32'h0000_0055, 2'b00, 0, 32'h0000_0055, 2'b00, 12);
        // Full channel, one flipped bit
        vecs[5] = mk(2'b10, 1, 2'b10, 2'b01, 32'h0000_1234, 32'h0001_0000,
                     4, -1, 32'h0000_1234, 2'b01, 0, 32'h0000_1234, 2'b01, 14);
        // Timeout, with a stray done during the write phase
        vecs[6] = mk(2'b01, 0, 2'b00, 2'b00, 32'h9, 32'h0,
                     -1, 4, 32'hDEAD_BEEF, 2'b11, 1, 32'h0, 2'b00, 24);
        // Illegal mode
        vecs[7] = mk(2'b10, 1, 2'b11, 2'b00, 32'hFFFF, 32'h0,
                     -1, -1, 32'h0, 2'b00, 1, 32'h0, 2'b00, 1);
        // Done on the last WAIT cycle wins over timeout
        vecs[8] = mk(2'b01, 0, 2'b01, 2'b10, 32'h8000_0001, 32'h0,
                     14, -1, 32'h0123_4567, 2'b10, 0, 32'h0123_4567, 2'b10, 24);
        vr = mk(2'b11, 0, 2'b00, 2'b00, 32'h42, 32'h0,
                1, -1, 32'h42, 2'b00, 0, 32'h42, 2'b00, 11);

        #3;
        chk("reset apb", 64'({PSEL, PENABLE, PWRITE, PADDR}), 64'(0));
        chk("reset pwdata", 64'(PWDATA), 64'(0));
        chk("reset rsp", 64'({rsp_valid, rsp_id, rsp_err, rsp_nerr}), 64'(0));
        chk("reset rsp_data", 64'(rsp_data), 64'(0));
        chk("reset ready", 64'(req_ready), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Request withdrawn before the edge: nothing accepted
        @(negedge clk);
        drive_req(vecs[0]);
        req_valid = 2'b01;
        #1 chk("withdraw ready_on", 64'(req_ready), 64'(2'b01));
        #2 req_valid = 2'b00;
        #1 chk("withdraw ready_off", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("withdraw no_apb", 64'(PSEL), 64'(0));

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during WR_ACCESS of the DATA_IN write
        @(negedge clk);
        drive_req(vr);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (5) @(negedge clk);
        chk("mid access", 64'({PSEL, PENABLE, PADDR}),
            64'({1'b1, 1'b1, 20'h4}));
        rst = 1'b0;
        #1 chk("async drop", 64'({PSEL, PENABLE}), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no rsp in reset", 64'(rsp_valid), 64'(0));
        end
        rst = 1'b1;
        run_vec(vr, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
